// File: rtl/div3_serial_scheduler.sv
// Round-robin scheduler sharing one serial MSB-first mod-3 residue engine
// between NREQ requesters; results return on a single id-tagged channel.
module div3_serial_scheduler #(
  parameter int W    = 8,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_id,
  output logic [1:0]        res_rem,
  output logic              res_div3,
  output logic              busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    id_q, id_d;
  logic [1:0]    rem_q, rem_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sr_q, sr_d;

  logic          found;
  logic [1:0]    win_id;
  logic          grant_en;

  // Requester index base+offs, wrapped modulo NREQ.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return 2'(s);
  endfunction

  // One step of the residue recurrence: (2*r + b) mod 3.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    case ({r, b})
      3'b000:  return 2'd0;
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b011:  return 2'd0;
      3'b100:  return 2'd1;
      3'b101:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && |(req_valid & (NREQ'(1) << rr_index(ptr_q, k)))) begin
        found  = 1'b1;
        win_id = rr_index(ptr_q, k);
      end
    end
  end

  assign grant_en  = resetn && (state_q == IDLE) && found;
  assign req_ready = grant_en ? (NREQ'(1) << win_id) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          sr_d    = req_data[int'(win_id)*W +: W];
          rem_d   = '0;
          cnt_d   = '0;
          id_d    = win_id;
          ptr_d   = rr_index(win_id, 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rem_d = mod3_step(rem_q, sr_q[W-1]);
        sr_d  = {sr_q[W-2:0], 1'b0};
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          div_d   = (rem_d == 2'd0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      rem_q   <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the shift register has no reset; it is always loaded on a grant
  // before any bit of it is consumed.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign res_valid = (state_q == DONE);
  assign res_id    = id_q;
  assign res_rem   = rem_q;
  assign res_div3  = div_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div3_serial_scheduler.sv
// Scoreboard bench for div3_serial_scheduler: a round-robin/arithmetic model
// predicts grants and results; a negedge monitor compares against the DUT.
module tb_div3_serial_scheduler;

  localparam int W    = 8;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [1:0]        res_rem;
  logic              res_div3;
  logic              busy;

  div3_serial_scheduler #(.W(W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_rem   (res_rem),
    .res_div3  (res_div3),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] rem;
    logic       div;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic         rst_edge = 1'b1;
  logic         gap_en   = 1'b0;
  int           grant_cnt = 0;

  logic [W-1:0] src0_q[$];
  logic [W-1:0] src1_q[$];
  exp_t         exp_q[$];
  int           res_cyc_q[$];

  // Reference model state
  logic         m_busy = 1'b0;
  int           m_ptr  = 0;
  int           m_due  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !resetn;
  end

  // Requester driver: presents queued words, holds them until transferred.
  logic [NREQ-1:0] xfer;
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (|xfer) grant_cnt++;
      if (xfer[0]) void'(src0_q.pop_front());
      if (xfer[1]) void'(src1_q.pop_front());
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = (i == 0) ? src0_q.size() : src1_q.size();
        if (n == 0) begin
          req_valid[i] = 1'b0;
          req_data[i*W +: W] = W'($urandom);
        end else if (req_valid[i] && !xfer[i]) begin
          req_valid[i] = 1'b1;
        end else if (gap_en && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b0;
          req_data[i*W +: W] = W'($urandom);
        end else begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = (i == 0) ? src0_q[0] : src1_q[0];
        end
      end
    end
  end

  // Monitor and reference model, evaluated mid-cycle.
  logic         idle_now;
  logic         exp_valid;
  logic         m_found;
  int           m_win;
  logic [NREQ-1:0] exp_ready;
  logic [W-1:0] m_word;
  int           m_rem;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        exp_q.delete();
        m_busy = 1'b0;
        m_ptr  = 0;
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_rem", res_rem, 0);
        check("rst_res_div3", res_div3, 0);
      end
      idle_now = !m_busy;
      if (!rst_edge) begin
        exp_valid = m_busy && (cyc >= m_due);
        check("res_valid", res_valid, exp_valid);
        check("busy", busy, m_busy);
        if (exp_valid && exp_q.size() > 0) begin
          check("res_id", res_id, exp_q[0].id);
          check("res_rem", res_rem, exp_q[0].rem);
          check("res_div3", res_div3, exp_q[0].div);
          if (res_ready) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            res_cyc_q.push_back(cyc);
          end
        end
      end
      m_found = 1'b0;
      m_win   = 0;
      if (resetn && idle_now) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!m_found && req_valid[(m_ptr + k) % NREQ]) begin
            m_found = 1'b1;
            m_win   = (m_ptr + k) % NREQ;
          end
        end
      end
      exp_ready = m_found ? NREQ'(1 << m_win) : '0;
      check("req_ready", req_ready, exp_ready);
      if (m_found) begin
        m_word = req_data[m_win*W +: W];
        m_rem  = int'(m_word) % 3;
        exp_q.push_back('{id: 2'(m_win), rem: 2'(m_rem), div: (m_rem == 0)});
        m_busy = 1'b1;
        m_due  = cyc + W + 1;
        m_ptr  = (m_win + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic [W-1:0] w);
    if (i == 0) src0_q.push_back(w);
    else        src1_q.push_back(w);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  initial begin
    int n;
    int g;
    int n0;
    resetn    = 1'b0;
    res_ready = 1'b1;

    // Reset with both requesters valid; first grant must go to requester 0.
    push(0, 8'd9);
    push(0, 8'd100);
    push(1, 8'd0);
    push(1, 8'd255);
    repeat (3) step();
    resetn = 1'b1;
    drain("drain_reset_phase", 200);

    // Arbitration: both valid, results W+2 cycles apart.
    n0 = res_cyc_q.size();
    push(0, 8'd7);
    push(1, 8'd6);
    push(0, 8'd7);
    push(1, 8'd6);
    drain("drain_arb", 200);
    check("arb_count", res_cyc_q.size() - n0, 4);
    for (int i = n0 + 1; i < res_cyc_q.size(); i++)
      check("arb_spacing", res_cyc_q[i] - res_cyc_q[i-1], W + 2);

    // Backpressure: result held while res_ready is low.
    res_ready = 1'b0;
    push(0, 8'd200);
    push(1, 8'd77);
    push(0, 8'd31);
    n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    check("bp_valid_seen", res_valid, 1);
    repeat (5) step();
    res_ready = 1'b1;
    drain("drain_bp", 200);

    // Reset three cycles after a grant of 128.
    g = grant_cnt;
    push(0, 8'd128);
    n = 0;
    while (grant_cnt == g && n < 50) begin
      step();
      n++;
    end
    check("midrst_grant_seen", (grant_cnt != g), 1);
    repeat (2) step();
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    repeat (3) step();
    push(0, 8'd128);
    push(1, 8'd3);
    drain("drain_midrst", 200);

    // Boundary words.
    push(0, 8'd255);
    push(0, 8'd254);
    push(1, 8'd0);
    drain("drain_boundary", 200);

    // Randomized traffic with valid gaps and random result backpressure.
    gap_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      push(0, W'($urandom));
      push(1, W'($urandom));
    end
    n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0 || busy) && n < 5000) begin
      res_ready = ($urandom_range(0, 2) != 0);
      step();
      n++;
    end
    check("random_done", (n < 5000), 1);
    res_ready = 1'b1;
    drain("drain_final", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
